// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: time-multiplexed 7-segment driver for packed BCD digits.
// Each edge of scan_in advances to the next digit. Digits are latched once per
// frame (when the scan wraps to digit 0), so a frame never mixes old and new values.
module seg7_scan_decoder #(
  parameter int N_DIGITS       = 4,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_in,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   bcd_in,
  input  logic [N_DIGITS-1:0]     dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic [2:0]              digit_idx
);

  localparam logic [6:0]          SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = (ACTIVE_LOW_SEG != 0);
  localparam logic [N_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW_AN != 0) ? '1 : '0;
  localparam logic [2:0]          LAST_IDX = 3'(N_DIGITS - 1);

  logic                    scan_q_reg;
  logic [2:0]              idx_reg;
  logic [4*N_DIGITS-1:0]   snap_reg;
  logic [N_DIGITS-1:0]     dp_snap_reg;
  logic [6:0]              seg_reg;
  logic                    dp_reg;
  logic [N_DIGITS-1:0]     an_reg;

  logic                    step;
  logic                    wrap;
  logic [2:0]              idx_next;
  logic [31:0]             snap_pad;
  logic [7:0]              dp_pad;
  logic [8:0]              lz;
  logic [3:0]              nibble;
  logic                    dp_raw;
  logic                    blank;
  logic [6:0]              pat;
  logic [N_DIGITS-1:0]     an_hot;
  logic [6:0]              seg_next;
  logic                    dp_next;
  logic [N_DIGITS-1:0]     an_next;

  // Zero-pad the snapshot to 8 digits so indexing by the 3-bit index is always in range.
  assign snap_pad = 32'(snap_reg);
  assign dp_pad   = 8'(dp_snap_reg);
  assign step     = (scan_in != scan_q_reg);

  // lz[i] = 1 when every snapshot digit from i up to the top is zero (leading zeros).
  assign lz[8] = 1'b1;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lz
      assign lz[gi] = lz[gi+1] && (snap_pad[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // Work out the next index and the drive pattern for the digit it selects.
  always_comb begin
    wrap     = (idx_reg == LAST_IDX);
    idx_next = wrap ? 3'd0 : idx_reg + 3'd1;
    // Digit 0 is shown straight from bcd_in on the edge the snapshot is taken.
    nibble   = wrap ? bcd_in[3:0] : snap_pad[{idx_next, 2'b00} +: 4];
    dp_raw   = wrap ? dp_mask[0] : dp_pad[idx_next];
    blank    = (BLANK_LEADING != 0) && !wrap && lz[idx_next];
    case (nibble)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hF:    pat = 7'h40;
      default: pat = 7'h00;
    endcase
    if (blank) pat = 7'h00;
    an_hot = '0;
    for (int i = 0; i < N_DIGITS; i++) an_hot[i] = (idx_next == 3'(i));
    seg_next = (ACTIVE_LOW_SEG != 0) ? ~pat : pat;
    dp_next  = (ACTIVE_LOW_SEG != 0) ? ~dp_raw : dp_raw;
    an_next  = (ACTIVE_LOW_AN != 0) ? ~an_hot : an_hot;
  end

  // Scan state, frame snapshot and registered display drive.
  always_ff @(posedge clk) begin
    scan_q_reg <= scan_in;
    if (rst) begin
      idx_reg     <= LAST_IDX;
      snap_reg    <= '0;
      dp_snap_reg <= '0;
      seg_reg     <= SEG_OFF;
      dp_reg      <= DP_OFF;
      an_reg      <= AN_OFF;
    end else if (!enable) begin
      seg_reg <= SEG_OFF;
      dp_reg  <= DP_OFF;
      an_reg  <= AN_OFF;
    end else if (step) begin
      idx_reg <= idx_next;
      if (wrap) begin
        snap_reg    <= bcd_in;
        dp_snap_reg <= dp_mask;
      end
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
      an_reg  <= an_next;
    end
  end

  assign seg       = seg_reg;
  assign dp        = dp_reg;
  assign an        = an_reg;
  assign digit_idx = idx_reg;

endmodule
